// File: rtl/mouse_axis_emu.sv
// ============================================================================
// mouse_axis_emu: PS/2 mouse motion packets to emulated analog joystick axes
// Rev 1.0
// ============================================================================
`default_nettype none

module mouse_axis_emu #(
  parameter int WIDTH        = 8,
  parameter int MAX_STEP     = 10,
  parameter int SHIFT        = 1,
  parameter int DECAY_DIV    = 96000,
  parameter int DECAY_STEP   = 1,
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [24:0]             ps2_mouse,
  input  logic signed [WIDTH-1:0] joy_x,
  input  logic signed [WIDTH-1:0] joy_y,
  input  logic                    joy_fire,
  input  logic                    joy_active,
  input  logic                    mouse_disable,  // OSD switch; "disable" is a reserved word
  input  logic                    centre_mode,
  output logic signed [WIDTH-1:0] out_x,
  output logic signed [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0]        adc_x,
  output logic [WIDTH-1:0]        adc_y,
  output logic                    out_fire,
  output logic                    emu_active
);

  localparam int c_DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int c_IW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [c_DW-1:0] c_DLAST = c_DW'(DECAY_DIV - 1);
  localparam logic [c_IW-1:0] c_IMAX  = c_IW'(IDLE_TIMEOUT);
  localparam logic [c_IW-1:0] c_ILAST = c_IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam logic signed [8:0] c_STEP_MAX = 9'(MAX_STEP);
  localparam logic signed [8:0] c_STEP_MIN = 9'(-MAX_STEP);
  localparam logic signed [WIDTH:0] c_SAT_MAX = (WIDTH+1)'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [WIDTH:0] c_SAT_MIN = (WIDTH+1)'(-(2 ** (WIDTH - 1)));
  localparam logic signed [WIDTH-1:0] c_DSTEP   = WIDTH'(DECAY_STEP);
  localparam logic signed [WIDTH-1:0] c_DSTEP_N = WIDTH'(-DECAY_STEP);

  function automatic logic signed [8:0] clamp_step(input logic signed [8:0] raw);
    logic signed [8:0] d;
    d = raw >>> SHIFT;
    if (d > c_STEP_MAX)      return c_STEP_MAX;
    else if (d < c_STEP_MIN) return c_STEP_MIN;
    else                     return d;
  endfunction

  // One guard bit is enough: the step is always far smaller than full scale.
  function automatic logic signed [WIDTH-1:0] accum(input logic signed [WIDTH-1:0] pos,
                                                    input logic signed [8:0] d);
    logic signed [WIDTH:0] s;
    s = (WIDTH+1)'(pos) + (WIDTH+1)'(d);
    if (s > c_SAT_MAX)      return c_SAT_MAX[WIDTH-1:0];
    else if (s < c_SAT_MIN) return c_SAT_MIN[WIDTH-1:0];
    else                    return s[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] decay(input logic signed [WIDTH-1:0] pos);
    if (pos > c_DSTEP)        return pos - c_DSTEP;
    else if (pos < c_DSTEP_N) return pos + c_DSTEP;
    else                      return '0;
  endfunction

  logic                    r_primed, r_old_stb, r_emu;
  logic signed [WIDTH-1:0] r_mx, r_my;
  logic [c_DW-1:0]         r_dcnt;
  logic [c_IW-1:0]         r_icnt;

  logic                    w_evt, w_ovr, w_tick;
  logic signed [8:0]       w_dx, w_dy;
  logic signed [WIDTH-1:0] w_mx_n, w_my_n;
  logic                    w_emu_n;
  logic [c_DW-1:0]         w_dcnt_n;
  logic [c_IW-1:0]         w_icnt_n;
  logic                    w_unused;

  assign w_unused = &{1'b0, ps2_mouse[7:6], ps2_mouse[3:2]};
  assign w_evt    = r_primed && (ps2_mouse[24] != r_old_stb);
  assign w_ovr    = joy_active | mouse_disable;
  assign w_tick   = centre_mode && (r_dcnt == c_DLAST);
  assign w_dx     = clamp_step($signed({ps2_mouse[4], ps2_mouse[15:8]}));
  assign w_dy     = -clamp_step($signed({ps2_mouse[5], ps2_mouse[23:16]}));

  always_comb begin
    w_mx_n   = r_mx;
    w_my_n   = r_my;
    w_emu_n  = r_emu;
    w_icnt_n = r_icnt;
    w_dcnt_n = '0;
    if (centre_mode && !w_tick)
      w_dcnt_n = r_dcnt + 1'b1;
    if ((IDLE_TIMEOUT > 0) && r_emu && (r_icnt != c_IMAX))
      w_icnt_n = r_icnt + 1'b1;

    // Priority: host override, then a new packet, then decay and timeout.
    if (w_ovr) begin
      w_mx_n   = '0;
      w_my_n   = '0;
      w_emu_n  = 1'b0;
      w_icnt_n = '0;
      w_dcnt_n = '0;
    end else if (w_evt) begin
      w_mx_n   = accum(r_mx, w_dx);
      w_my_n   = accum(r_my, w_dy);
      w_emu_n  = 1'b1;
      w_icnt_n = '0;
    end else begin
      if (w_tick) begin
        w_mx_n = decay(r_mx);
        w_my_n = decay(r_my);
      end
      if ((IDLE_TIMEOUT > 0) && r_emu && (r_icnt == c_ILAST)) begin
        w_emu_n = 1'b0;
        w_mx_n  = '0;
        w_my_n  = '0;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_primed  <= 1'b0;
      r_old_stb <= 1'b0;
      r_emu     <= 1'b0;
      r_mx      <= '0;
      r_my      <= '0;
      r_dcnt    <= '0;
      r_icnt    <= '0;
    end else begin
      r_primed  <= 1'b1;
      r_old_stb <= ps2_mouse[24];
      r_emu     <= w_emu_n;
      r_mx      <= w_mx_n;
      r_my      <= w_my_n;
      r_dcnt    <= w_dcnt_n;
      r_icnt    <= w_icnt_n;
    end
  end

  assign out_x      = r_emu ? r_mx : joy_x;
  assign out_y      = r_emu ? r_my : joy_y;
  assign out_fire   = r_emu ? (ps2_mouse[0] | ps2_mouse[1]) : joy_fire;
  assign emu_active = r_emu;
  assign adc_x      = {out_x[WIDTH-1], ~out_x[WIDTH-2:0]};
  assign adc_y      = {out_y[WIDTH-1], ~out_y[WIDTH-2:0]};

endmodule

`default_nettype wire

// File: tb/tb_mouse_axis_emu.sv
// ============================================================================
// tb_mouse_axis_emu: directed bench for mouse_axis_emu (defaults, decay, idle)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mouse_axis_emu;
  localparam int W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [24:0]        ps2;
  logic signed [W-1:0] jx, jy;
  logic               jfire, jact, jdis, cmode;

  logic signed [W-1:0] a_ox, a_oy, d_ox, d_oy, i_ox, i_oy;
  logic [W-1:0]        a_ax, a_ay, d_ax, d_ay, i_ax, i_ay;
  logic                a_fire, a_emu, d_fire, d_emu, i_fire, i_emu;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mouse_axis_emu #(.WIDTH(W)) u_dut (
    .clk_sys(clk), .reset(rst), .ps2_mouse(ps2), .joy_x(jx), .joy_y(jy),
    .joy_fire(jfire), .joy_active(jact), .mouse_disable(jdis), .centre_mode(cmode),
    .out_x(a_ox), .out_y(a_oy), .adc_x(a_ax), .adc_y(a_ay),
    .out_fire(a_fire), .emu_active(a_emu)
  );

  mouse_axis_emu #(.WIDTH(W), .DECAY_DIV(4), .DECAY_STEP(2)) u_dec (
    .clk_sys(clk), .reset(rst), .ps2_mouse(ps2), .joy_x(jx), .joy_y(jy),
    .joy_fire(jfire), .joy_active(jact), .mouse_disable(jdis), .centre_mode(cmode),
    .out_x(d_ox), .out_y(d_oy), .adc_x(d_ax), .adc_y(d_ay),
    .out_fire(d_fire), .emu_active(d_emu)
  );

  mouse_axis_emu #(.WIDTH(W), .IDLE_TIMEOUT(8)) u_idl (
    .clk_sys(clk), .reset(rst), .ps2_mouse(ps2), .joy_x(jx), .joy_y(jy),
    .joy_fire(jfire), .joy_active(jact), .mouse_disable(jdis), .centre_mode(cmode),
    .out_x(i_ox), .out_y(i_oy), .adc_x(i_ax), .adc_y(i_ay),
    .out_fire(i_fire), .emu_active(i_emu)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Toggle the strobe with a new packet, then return after the capturing edge.
  task automatic send(input logic [7:0] xb, input logic xs, input logic [7:0] yb,
                      input logic ys, input logic [2:0] btn);
    ps2 = {~ps2[24], yb, xb, 2'b00, ys, xs, 1'b0, btn};
    @(negedge clk);
  endtask

  task automatic zero_pos();
    jdis = 1'b1;
    @(negedge clk);
    jdis = 1'b0;
    check("disable_clears", {31'b0, a_emu}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ps2 = 25'h1000000; jx = 8'h11; jy = 8'h22;
    jfire = 1'b1; jact = 1'b0; jdis = 1'b0; cmode = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_emu",  {31'b0, a_emu}, 0);
    check("rst_x",    $signed(a_ox), 32'sh11);
    check("rst_y",    $signed(a_oy), 32'sh22);
    check("rst_fire", {31'b0, a_fire}, 1);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("prime_no_event", {31'b0, a_emu}, 0);

    send(8'h08, 1'b0, 8'h00, 1'b0, 3'b000);
    check("ev1_emu",  {31'b0, a_emu}, 1);
    check("ev1_x",    $signed(a_ox), 4);
    check("ev1_adcx", {24'b0, a_ax}, 32'h7B);
    check("ev1_y",    $signed(a_oy), 0);
    check("ev1_fire", {31'b0, a_fire}, 0);

    zero_pos();
    for (int k = 1; k <= 13; k++) begin
      send(8'h7F, 1'b0, 8'h00, 1'b0, 3'b000);
      check("pos_clamp_x", $signed(a_ox), (10 * k > 127) ? 127 : 10 * k);
    end
    check("pos_sat_adcx", {24'b0, a_ax}, 32'h00);

    zero_pos();
    for (int k = 1; k <= 14; k++) begin
      send(8'h00, 1'b1, 8'h00, 1'b0, 3'b000);
      check("neg_clamp_x", $signed(a_ox), (-10 * k < -128) ? -128 : -10 * k);
    end
    send(8'h00, 1'b0, 8'h10, 1'b0, 3'b000);
    check("y_invert",     $signed(a_oy), -8);
    check("neg_hold_x",   $signed(a_ox), -128);
    check("neg_sat_adcx", {24'b0, a_ax}, 32'hFF);

    jx = 8'h20; jact = 1'b1;
    send(8'h08, 1'b0, 8'h00, 1'b0, 3'b000);
    check("ovr_emu", {31'b0, a_emu}, 0);
    check("ovr_x",   $signed(a_ox), 32'sh20);
    jact = 1'b0;
    @(negedge clk);
    check("ovr_event_dropped", {31'b0, a_emu}, 0);
    send(8'h08, 1'b0, 8'h00, 1'b0, 3'b000);
    check("ovr_restart_x", $signed(a_ox), 4);
    check("ovr_restart_emu", {31'b0, a_emu}, 1);

    jx = 8'h33; jy = 8'h44; jfire = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_emu", {31'b0, a_emu}, 0);
    check("async_rst_x",   $signed(a_ox), 32'sh33);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send(8'h0A, 1'b0, 8'h06, 1'b0, 3'b001);
    cmode = 1'b1;
    check("dec_start_x", $signed(d_ox), 5);
    check("dec_start_y", $signed(d_oy), -3);
    check("idl_emu0",    {31'b0, i_emu}, 1);
    check("idl_fire",    {31'b0, i_fire}, 1);
    repeat (3) @(negedge clk);
    check("dec_pre_tick_x", $signed(d_ox), 5);
    @(negedge clk);
    check("dec_t1_x", $signed(d_ox), 3);
    check("dec_t1_y", $signed(d_oy), -1);
    repeat (3) @(negedge clk);
    check("idl_emu7", {31'b0, i_emu}, 1);
    @(negedge clk);
    check("idl_emu8",  {31'b0, i_emu}, 0);
    check("idl_x",     $signed(i_ox), 32'sh33);
    check("idl_fire8", {31'b0, i_fire}, 0);
    check("dec_t2_x",  $signed(d_ox), 1);
    check("dec_t2_y",  $signed(d_oy), 0);
    repeat (4) @(negedge clk);
    check("dec_t3_x", $signed(d_ox), 0);
    repeat (4) @(negedge clk);
    check("dec_hold_x",  $signed(d_ox), 0);
    check("dec_hold_emu", {31'b0, d_emu}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mouse_axis_emu.md
Name: mouse_axis_emu

Overview:
- Converts PS/2 mouse motion packets from hps_io into a pair of emulated analog joystick axes plus a fire button, for cores with an analog joystick ADC (BBC/Electron style).
- Generalised successor of the inline mouse-as-joystick logic: parametrised output width, step clamp and delta scaling; adds an optional self-centring decay and an idle timeout.
- Sits between hps_io (ps2_mouse, joystick_analog) and the core's joystick inputs.

Parameters:
- WIDTH, 8, axis width in bits (8..12), two's complement.
- MAX_STEP, 10, maximum magnitude applied per mouse packet, per axis.
- SHIFT, 1, arithmetic right shift applied to the raw 9-bit delta before clamping.
- DECAY_DIV, 96000, clk_sys cycles per self-centre step.
- DECAY_STEP, 1, magnitude removed per decay step.
- IDLE_TIMEOUT, 0, cycles without a packet before emulation drops out; 0 disables the timeout.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high
- ps2_mouse  in  25  hps_io format: [24] strobe toggle, [23:16] Y byte, [15:8] X byte, [5] Y sign, [4] X sign, [2:0] buttons
- joy_x, joy_y  in  WIDTH  host analog axes, signed
- joy_fire  in  1  host fire button
- joy_active  in  1  any host digital joystick bit set
- disable  in  1  OSD "mouse as joystick" off
- centre_mode  in  1  0 = hold position, 1 = self-centre
- out_x, out_y  out  WIDTH  selected axis, signed
- adc_x, adc_y  out  WIDTH  inverted offset-binary: {out[W-1], ~out[W-2:0]}
- out_fire  out  1  selected fire
- emu_active  out  1  mouse currently owns the axes

Behaviour:
- Reset:
  - mx, my, emu_active, counters and old_stb are 0.
  - The primed flag is 0.
  - Outputs therefore pass joy_x, joy_y and joy_fire through.
- Strobe detection:
  - The first cycle after reset copies ps2_mouse[24] into old_stb, sets primed, and generates no event.
  - After that, an event occurs when ps2_mouse[24] != old_stb; old_stb is updated every cycle.
- Delta arithmetic, per axis:
  - raw = signed 9-bit {sign, byte}.
  - d = raw >>> SHIFT.
  - d is clamped to [-MAX_STEP, +MAX_STEP].
  - X uses +d; Y uses -d (mouse up = joystick up).
- Accumulate:
  - The sum is computed in WIDTH+1 bits.
  - The result saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; no wrap-around.
- On an event:
  - mx and my are updated.
  - emu_active is set to 1.
  - The idle counter is cleared.
  - Outputs reflect the new value on the following cycle (1-cycle latency from the strobe change).
- Self-centre, when centre_mode=1:
  - The decay counter counts 0..DECAY_DIV-1 and ticks on wrap.
  - On a tick, each nonzero axis moves toward 0 by DECAY_STEP; it clamps at 0 and never overshoots.
  - Event and tick in the same cycle: the event update wins, decay is skipped for that tick, and the counter still wraps.
  - When centre_mode=0 the counter is held at 0.
- Idle timeout, when IDLE_TIMEOUT>0:
  - The idle counter increments while emu_active=1 and saturates at IDLE_TIMEOUT.
  - On reaching IDLE_TIMEOUT: emu_active=0, mx=my=0.
- Override:
  - joy_active=1 or disable=1 forces emu_active=0, mx=my=0 and clears all counters.
  - Override has priority over an event in the same cycle; that event is dropped, but old_stb still updates.
- Output mux:
  - emu_active=1: out = mx/my, out_fire = ps2_mouse[0] | ps2_mouse[1].
  - emu_active=0: out = joy_x/joy_y, out_fire = joy_fire.
  - The mux is combinational from registered state.
- Reset asserted mid-operation clears all state immediately, asynchronously.

Test Plan:
- Defaults. Reset, hold strobe steady for 3 cycles, then toggle it with X byte=0x08, sign 0 -> emu_active=1 next cycle, out_x=4, adc_x=0x7B, out_y=0. There is no event from the priming cycle even if the strobe is 1 at reset release.
- X byte=0x7F, sign 0, repeated 13 events -> each step clamps to 10; out_x goes 10, 20 … 120, then 127 (saturated); adc_x=0x00.
- X sign=1, byte=0x00 (-256 → -128 → clamp -10), 14 events -> out_x=-128 (0x80), no wrap. Y byte=0x10, sign 0 -> out_y=-8 (0xF8).
- Event and joy_active=1 in the same cycle, joy_x=0x20 -> emu_active=0, out_x=0x20, mx=0. A subsequent event with joy_active=0 restarts from mx=0.
- Bench DECAY_DIV=4, DECAY_STEP=2, centre_mode=1, out_x=5 -> 3, 1, 0 at 4-cycle intervals, holding 0. Out_y=-3 -> -1, 0.
- Bench IDLE_TIMEOUT=8. One event, then no strobe -> emu_active drops 8 cycles later and outputs revert to joy_x/joy_y. Buttons[0]=1 while active -> out_fire=1.
